if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Instruction-fetch stage of the MIPS pipeline: owns the program counter, drives the combinational instruction memory, and buffers fetched instructions with their PCs in a small queue. Decode consumes them through a valid/ready handshake. Branch/jump resolution downstream redirects the fetch via a single-cycle redirect strobe, which flushes the queue.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, PC loaded on reset
- IM_AW, 5, instruction-memory word-address width
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- ImAdr  out  IM_AW  instruction-memory word index = PC[IM_AW+1:2]
- ImData  in  32  instruction word, combinational return for ImAdr
- Redirect  in  1  one-cycle strobe: flush and restart at RedirectPc
- RedirectPc  in  32  redirect target; bits [1:0] ignored (treated as 0)
- IfValid  out  1  head entry available to decode
- IfReady  in  1  decode accepts head this cycle
- IfInstr  out  32  head instruction
- IfPc  out  32  head PC
- IfPcPlus4  out  32  IfPc + 4, mod 2^32
- StallCnt  out  16  backpressure counter (only with FETCH_STAT_EN)

## Operation
- State: PC register, DEPTH-entry queue of {instr, pc}, read/write pointers, count (0..DEPTH).
- pop = IfValid & IfReady. push = !Redirect & (count<DEPTH | pop).
- On push: write {ImData, PC} at write pointer; PC <= PC + 4, wrapping 32'hFFFF_FFFC -> 0.
- Full with simultaneous pop: push still occurs; count unchanged.
- Redirect has priority over all events: count, pointers cleared; PC <= {RedirectPc[31:2], 2'b00}; no push; pop suppressed.
- IfValid = (count != 0) & !Redirect; combinational on Redirect only.
- IfInstr/IfPc/IfPcPlus4 come from the head entry's storage; values are don't-care when IfValid=0 but must not be X after reset (storage reset to 0).
- ImAdr always reflects the current PC, including while full.
- Reset (any time, including mid-stream): PC=RESET_PC, count=0, pointers=0, storage=0, IfValid=0, StallCnt=0, taking effect immediately.

## Timing
- Fetch latency: an instruction fetched at edge n is visible on IfValid/IfInstr after edge n.
- First instruction after reset release: IfValid=1 one cycle after the first rising edge with Reset high.
- Steady state with IfReady=1: one instruction per cycle, no bubbles.
- Redirect penalty: IfValid=0 in the redirect cycle and in the following cycle; the target instruction is valid in the second cycle after the redirect.
- Backpressure: queue fills DEPTH cycles after IfReady drops (if previously empty); PC then freezes.

## Configuration
- FETCH_STAT_EN defined: StallCnt port present; it increments on each edge with IfValid=1 & IfReady=0, saturates at 16'hFFFF, and is cleared only by Reset (not by Redirect).
- Undefined: StallCnt port and counter absent; all other behaviour identical.

## Structure
- Shared package mips_pkg: instruction/address width constants (32), default RESET_PC, PC increment (4).
- One sub-module: fetch_fifo — parametric synchronous FIFO (DEPTH, 64-bit data) with push/pop/flush, count output, async active-low reset. The PC logic and handshake stay in if_fetch_queue.

## Test plan
- Reset release, IfReady=1, IM word i = 32'h1000_0000+i -> IfPc 0,4,8,… with IfInstr 0x10000000, 0x10000001, … on consecutive cycles, no gaps.
- IfReady=0 from reset for 10 cycles -> count reaches 4, ImAdr holds 4 (PC=0x10), IfPc=0 held, StallCnt=9 (with macro); IfReady=1 -> IfPc 0,4,8,C,10,14 back-to-back.
- Queue holding 3 entries, Redirect=1 with RedirectPc=0x40 -> IfValid=0 that cycle and the next, then IfPc=0x40, 0x44; none of the old entries appear.
- RedirectPc=0x43 -> fetch restarts at 0x40, ImAdr=16.
- Reset asserted asynchronously between edges mid-stream -> IfValid drops immediately; after release the sequence restarts at RESET_PC.
- RESET_PC=32'hFFFF_FFF8 -> IfPc FFFFFFF8, FFFFFFFC, 00000000; IfPcPlus4 for the FFFFFFFC entry = 0x0000_0000, and for the 0x00000000 entry = 0x0000_0004.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS constants: datapath width, default reset PC, PC step and fetch-entry layout.
// Latency: none (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC           = 32'd4;

  // One queued fetch: the instruction word and the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetchEntryT;

  // Sequential PC; wraps naturally from 32'hFFFF_FFFC to 0.
  function automatic logic [XLEN-1:0] pcNext(input logic [XLEN-1:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetch entries, with flush and an occupancy count.
// Latency: a push at edge n is visible on HeadData after edge n (head is read combinationally).
// Backpressure: none internally; the caller must not push when full unless it pops in the same cycle.
// Ports: Clk, Reset (async active-low), Push/PushData, Pop, Flush (wins over push/pop),
//        HeadData (entry at read pointer), Count (0..DEPTH).
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 64
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Push,
  input  logic [DW-1:0]          PushData,
  input  logic                   Pop,
  input  logic                   Flush,
  output logic [DW-1:0]          HeadData,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] cnt;

  assign HeadData = mem[rdPtr];
  assign Count    = cnt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
      // Storage is cleared too so the head outputs are never X after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (Flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      // When full with a simultaneous pop, wrPtr == rdPtr: the old head is read
      // this cycle and overwritten at the edge, which is exactly what we want.
      if (Push) begin
        mem[wrPtr] <= PushData;
        wrPtr      <= wrPtr + PW'(1);
      end
      if (Pop) rdPtr <= rdPtr + PW'(1);
      case ({Push, Pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// MIPS instruction fetch: owns the PC, addresses the combinational IM and queues {instr, pc} for decode.
// Latency: an instruction fetched at edge n is valid to decode after edge n; a redirect costs two bubble cycles.
// Backpressure: valid/ready to decode; when the queue is full and decode stalls, the PC freezes.
// Ports: Clk, Reset (async active-low); ImAdr/ImData to instruction memory; Redirect/RedirectPc from
//        branch resolution (flushes the queue); IfValid/IfReady/IfInstr/IfPc/IfPcPlus4 to decode;
//        StallCnt (saturating backpressure counter) only when FETCH_STAT_EN is defined.
module if_fetch_queue
  import mips_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          IM_AW    = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  output logic [IM_AW-1:0] ImAdr,
  input  logic [31:0]      ImData,
  input  logic             Redirect,
  input  logic [31:0]      RedirectPc,
  output logic             IfValid,
  input  logic             IfReady,
  output logic [31:0]      IfInstr,
  output logic [31:0]      IfPc,
  output logic [31:0]      IfPcPlus4
`ifdef FETCH_STAT_EN
  ,
  output logic [15:0]      StallCnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc;
  logic [CW-1:0] count;
  logic          full;
  logic          push;
  logic          pop;
  fetchEntryT    wrEntry;
  fetchEntryT    head;

  assign full    = (count == CW'(DEPTH));
  // Redirect hides the head immediately so decode never consumes a stale entry.
  assign IfValid = (count != '0) && !Redirect;
  assign pop     = IfValid && IfReady;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign push    = !Redirect && (!full || pop);

  assign ImAdr   = pc[IM_AW+1:2];
  assign wrEntry = '{instr: ImData, pc: pc};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .DW    ($bits(fetchEntryT))
  ) uFifo (
    .Clk      (Clk),
    .Reset    (Reset),
    .Push     (push),
    .PushData (wrEntry),
    .Pop      (pop),
    .Flush    (Redirect),
    .HeadData (head),
    .Count    (count)
  );

  assign IfInstr   = head.instr;
  assign IfPc      = head.pc;
  assign IfPcPlus4 = pcNext(head.pc);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc <= RESET_PC;
    end else if (Redirect) begin
      pc <= RedirectPc & ~32'h3;
    end else if (push) begin
      pc <= pcNext(pc);
    end
  end

`ifdef FETCH_STAT_EN
  logic [15:0] stallCnt;

  assign StallCnt = stallCnt;

  // Counts cycles where decode holds off a valid head; not cleared by redirect.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stallCnt <= '0;
    end else if (IfValid && !IfReady && (stallCnt != 16'hFFFF)) begin
      stallCnt <= stallCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios then randomized traffic against a queue-based model.
// Latency: n/a.
// Backpressure: IfReady and Redirect are driven randomly.
module tb_if_fetch_queue;

  localparam int          DEPTH = 4;
  localparam int          IM_AW = 5;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] HI_PC  = 32'hFFFF_FFF8;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entT;

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic [IM_AW-1:0] ImAdr, ImAdrHi;
  logic [31:0]      ImData, ImDataHi;
  logic             Redirect = 1'b0;
  logic [31:0]      RedirectPc = '0;
  logic             IfValid, IfValidHi;
  logic             IfReady = 1'b0;
  logic [31:0]      IfInstr, IfPc, IfPcPlus4;
  logic [31:0]      IfInstrHi, IfPcHi, IfPcPlus4Hi;
`ifdef FETCH_STAT_EN
  logic [15:0]      StallCnt, StallCntHi;
`endif

  logic [31:0] imem [2**IM_AW];

  assign ImData   = imem[ImAdr];
  assign ImDataHi = imem[ImAdrHi];

  always #5 Clk = ~Clk;

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC), .IM_AW(IM_AW)) uDut (
    .Clk(Clk), .Reset(Reset), .ImAdr(ImAdr), .ImData(ImData),
    .Redirect(Redirect), .RedirectPc(RedirectPc),
    .IfValid(IfValid), .IfReady(IfReady),
    .IfInstr(IfInstr), .IfPc(IfPc), .IfPcPlus4(IfPcPlus4)
`ifdef FETCH_STAT_EN
    , .StallCnt(StallCnt)
`endif
  );

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(HI_PC), .IM_AW(IM_AW)) uDutHi (
    .Clk(Clk), .Reset(Reset), .ImAdr(ImAdrHi), .ImData(ImDataHi),
    .Redirect(Redirect), .RedirectPc(RedirectPc),
    .IfValid(IfValidHi), .IfReady(IfReady),
    .IfInstr(IfInstrHi), .IfPc(IfPcHi), .IfPcPlus4(IfPcPlus4Hi)
`ifdef FETCH_STAT_EN
    , .StallCnt(StallCntHi)
`endif
  );

  int passCnt  = 0;
  int totalCnt = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: fetched entries in order, the fetch PC and the stall counter.
  entT         mq[$];
  logic [31:0] mPc;
  logic [15:0] mStall;

  task automatic resetModel();
    mq.delete();
    mPc    = RST_PC;
    mStall = '0;
  endtask

  // Drive one cycle's inputs, compare outputs against the model, then advance one edge.
  task automatic step(input logic r, input logic [31:0] rpc, input logic rdy);
    logic expValid, doPop, doPush;
    entT  e;
    Redirect   = r;
    RedirectPc = rpc;
    IfReady    = rdy;
    #1;
    expValid = (mq.size() != 0) && !r;
    checkVal("IfValid", 32'(IfValid), 32'(expValid));
    checkVal("ImAdr", 32'(ImAdr), 32'(mPc[IM_AW+1:2]));
    if (expValid) begin
      checkVal("IfInstr", IfInstr, mq[0].instr);
      checkVal("IfPc", IfPc, mq[0].pc);
      checkVal("IfPcPlus4", IfPcPlus4, mq[0].pc + 32'd4);
    end
`ifdef FETCH_STAT_EN
    checkVal("StallCnt", 32'(StallCnt), 32'(mStall));
`endif
    if (expValid && !rdy && mStall != 16'hFFFF) mStall++;
    if (r) begin
      mq.delete();
      mPc = rpc & ~32'h3;
    end else begin
      doPop  = expValid && rdy;
      doPush = (mq.size() < DEPTH) || doPop;
      if (doPop) void'(mq.pop_front());
      if (doPush) begin
        e.instr = imem[mPc[IM_AW+1:2]];
        e.pc    = mPc;
        mq.push_back(e);
        mPc = mPc + 32'd4;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  // Assert reset wherever we are (mid-cycle), check immediate effect, release on a falling edge.
  task automatic doReset();
    Redirect = 1'b0;
    Reset    = 1'b0;
    #1;
    checkVal("rstIfValid", 32'(IfValid), 32'd0);
    checkVal("rstImAdr", 32'(ImAdr), 32'(RST_PC[IM_AW+1:2]));
    checkVal("rstIfInstr", IfInstr, 32'd0);
    checkVal("rstIfPc", IfPc, 32'd0);
`ifdef FETCH_STAT_EN
    checkVal("rstStallCnt", 32'(StallCnt), 32'd0);
`endif
    resetModel();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    logic [31:0] hiPc;
    for (int i = 0; i < 2**IM_AW; i++) imem[i] = 32'h1000_0000 + i;

    // Streaming from reset with decode always ready; high-PC instance checks wrap.
    doReset();
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 32'h0, 1'b1);
      hiPc = HI_PC + 32'(4 * (i - 1));
      checkVal("hiValid", 32'(IfValidHi), 32'd1);
      checkVal("hiPc", IfPcHi, hiPc);
      checkVal("hiPcPlus4", IfPcPlus4Hi, hiPc + 32'd4);
      checkVal("hiInstr", IfInstrHi, 32'h1000_0000 + 32'(hiPc[IM_AW+1:2]));
    end

    // Backpressure from reset: queue fills, PC freezes, then drains back-to-back.
    #2;
    doReset();
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);
    checkVal("fullImAdr", 32'(ImAdr), 32'd4);
    checkVal("fullIfPc", IfPc, 32'd0);
`ifdef FETCH_STAT_EN
    checkVal("fullStall", 32'(StallCnt), 32'd9);
`endif
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

    // Redirect with three queued entries.
    #2;
    doReset();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h40, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

    // Misaligned redirect target.
    step(1'b1, 32'h43, 1'b1);
    checkVal("redirImAdr", 32'(ImAdr), 32'd16);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);

    // Asynchronous reset mid-stream, between clock edges.
    #2;
    doReset();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

    // Randomized traffic with random IM contents.
    for (int i = 0; i < 2**IM_AW; i++) imem[i] = $urandom;
    for (int i = 0; i < 1500; i++) begin
      logic        r;
      logic [31:0] rpc;
      if (i == 750) begin
        #3;
        doReset();
      end
      r   = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? HI_PC : $urandom;
      step(r, rpc, ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
